// File: rtl/tf0060dca_dac_rx_pkg.sv
// Shared types and constants for the serial DAC link receiver.
// Frame layout: 8-bit address then 8-bit data, MSB first.
package tf0060dca_dac_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_e;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_BITS  = 8;
  localparam int DATA_BITS  = 8;
  localparam int CNT_BITS   = 5;

  localparam logic [CNT_BITS-1:0]  CNT_MAX      = 5'd31;
  localparam logic [ADDR_BITS-1:0] CH1_ADDR_DEF = 8'h00;
  localparam logic [ADDR_BITS-1:0] CH2_ADDR_DEF = 8'h01;

endpackage

// File: rtl/tf0060dca_sync_edge.sv
// Multi-flop synchroniser with rise/fall detection against a delayed copy.
// Flops reset to 1, the idle level of the link.
module tf0060dca_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/tf0060dca_dac_rx.sv
// Serial DAC link receiver: deserialises address/data frames into two
// channel sample registers and a registered 9-bit mix.
module tf0060dca_dac_rx
  import tf0060dca_dac_rx_pkg::*;
#(
  parameter int              SYNC_STAGES  = 2,
  parameter logic [7:0]      CH1_ADDR     = CH1_ADDR_DEF,
  parameter logic [7:0]      CH2_ADDR     = CH2_ADDR_DEF,
  parameter logic [7:0]      RESET_SAMPLE = 8'h80
) (
  input  logic       CLK_SYS,
  input  logic       RESET,
  input  logic       SCLK,
  input  logic       LOAD_SHIFT,
  input  logic       DI,
  output logic [7:0] CH1_OUT,
  output logic [7:0] CH2_OUT,
  output logic       CH1_STB,
  output logic       CH2_STB,
  output logic [8:0] MIX_OUT,
  output logic       FRAME_ERR
);

  localparam logic [8:0] MIX_RST =
    {1'b0, RESET_SAMPLE} + {1'b0, RESET_SAMPLE};

  logic w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic w_load_q, w_load_rise, w_load_fall;
  logic w_di_q, w_di_rise, w_di_fall;
  logic w_unused_sync;

  tf0060dca_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
    .i_clk  (CLK_SYS),
    .i_rst  (RESET),
    .i_d    (SCLK),
    .o_q    (w_sclk_q),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  tf0060dca_sync_edge #(.STAGES(SYNC_STAGES)) u_load (
    .i_clk  (CLK_SYS),
    .i_rst  (RESET),
    .i_d    (LOAD_SHIFT),
    .o_q    (w_load_q),
    .o_rise (w_load_rise),
    .o_fall (w_load_fall)
  );

  tf0060dca_sync_edge #(.STAGES(SYNC_STAGES)) u_di (
    .i_clk  (CLK_SYS),
    .i_rst  (RESET),
    .i_d    (DI),
    .o_q    (w_di_q),
    .o_rise (w_di_rise),
    .o_fall (w_di_fall)
  );

  assign w_unused_sync = ^{w_sclk_q, w_sclk_fall, w_load_q,
                           w_di_rise, w_di_fall};

  state_e                r_state, w_state_nx;
  logic [CNT_BITS-1:0]   r_cnt, w_cnt_nx;
  logic [FRAME_BITS-1:0] r_sr, w_sr_nx;
  logic                  w_full, w_hit1, w_hit2, w_err;
  logic [7:0]            r_ch1, r_ch2;
  logic                  r_stb1, r_stb2, r_err;
  logic [8:0]            r_mix;

  always_ff @(posedge CLK_SYS or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_sr    <= w_sr_nx;
    end
  end

  // Bit and frame end in the same cycle: the bit still counts.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_sr_nx    = r_sr;
    unique case (r_state)
      ST_IDLE: begin
        if (w_load_fall) begin
          w_cnt_nx   = '0;
          w_sr_nx    = '0;
          w_state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_load_fall) begin
          w_cnt_nx = '0;
          w_sr_nx  = '0;
        end else begin
          if (w_sclk_rise) begin
            w_sr_nx = {r_sr[FRAME_BITS-2:0], w_di_q};
            if (r_cnt != CNT_MAX) w_cnt_nx = r_cnt + 5'd1;
          end
          if (w_load_rise) w_state_nx = ST_COMMIT;
        end
      end
      ST_COMMIT: w_state_nx = ST_IDLE;
      default:   w_state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    w_full = (r_state == ST_COMMIT) &&
             (r_cnt == CNT_BITS'(FRAME_BITS));
    w_hit1 = w_full && (r_sr[15:8] == CH1_ADDR);
    w_hit2 = w_full && !w_hit1 && (r_sr[15:8] == CH2_ADDR);
    w_err  = (r_state == ST_COMMIT) && !w_full;
  end

  always_ff @(posedge CLK_SYS or posedge RESET) begin
    if (RESET) begin
      r_ch1  <= RESET_SAMPLE;
      r_ch2  <= RESET_SAMPLE;
      r_stb1 <= 1'b0;
      r_stb2 <= 1'b0;
      r_err  <= 1'b0;
      r_mix  <= MIX_RST;
    end else begin
      r_stb1 <= w_hit1;
      r_stb2 <= w_hit2;
      r_err  <= w_err;
      if (w_hit1) r_ch1 <= r_sr[DATA_BITS-1:0];
      if (w_hit2) r_ch2 <= r_sr[DATA_BITS-1:0];
      r_mix  <= {1'b0, r_ch1} + {1'b0, r_ch2};
    end
  end

  assign CH1_OUT   = r_ch1;
  assign CH2_OUT   = r_ch2;
  assign CH1_STB   = r_stb1;
  assign CH2_STB   = r_stb2;
  assign FRAME_ERR = r_err;
  assign MIX_OUT   = r_mix;

endmodule

// File: tb/tb_tf0060dca_dac_rx.sv
// Directed bench for the serial DAC link receiver.
// SCLK runs at CLK_SYS/4; expected values are hand-computed constants.
module tb_tf0060dca_dac_rx;

  logic       CLK_SYS = 1'b0;
  logic       RESET;
  logic       SCLK;
  logic       LOAD_SHIFT;
  logic       DI;
  logic [7:0] CH1_OUT, CH2_OUT;
  logic       CH1_STB, CH2_STB, FRAME_ERR;
  logic [8:0] MIX_OUT;

  int tests = 0;
  int fails = 0;
  int n1 = 0;
  int n2 = 0;
  int ne = 0;

  tf0060dca_dac_rx dut (
    .CLK_SYS    (CLK_SYS),
    .RESET      (RESET),
    .SCLK       (SCLK),
    .LOAD_SHIFT (LOAD_SHIFT),
    .DI         (DI),
    .CH1_OUT    (CH1_OUT),
    .CH2_OUT    (CH2_OUT),
    .CH1_STB    (CH1_STB),
    .CH2_STB    (CH2_STB),
    .MIX_OUT    (MIX_OUT),
    .FRAME_ERR  (FRAME_ERR)
  );

  always #5 CLK_SYS = ~CLK_SYS;

  always @(posedge CLK_SYS) begin
    if (CH1_STB)   n1 <= n1 + 1;
    if (CH2_STB)   n2 <= n2 + 1;
    if (FRAME_ERR) ne <= ne + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK_SYS);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] w, input int nb);
    LOAD_SHIFT = 1'b0;
    tick(4);
    for (int i = 0; i < nb; i++) begin
      SCLK = 1'b0;
      DI   = (i < 16) ? w[15-i] : 1'b0;
      tick(2);
      SCLK = 1'b1;
      tick(2);
    end
  endtask

  task automatic end_frame();
    LOAD_SHIFT = 1'b1;
    tick(8);
  endtask

  task automatic send_frame(input logic [15:0] w, input int nb);
    send_bits(w, nb);
    end_frame();
  endtask

  task automatic test_reset();
    tests++;
    if (CH1_OUT !== 8'h80 || CH2_OUT !== 8'h80) begin
      fails++;
      $display("FAIL reset_ch: got %h/%h exp 80/80", CH1_OUT, CH2_OUT);
    end
    tests++;
    if (MIX_OUT !== 9'h100) begin
      fails++;
      $display("FAIL reset_mix: got %h exp 100", MIX_OUT);
    end
    tests++;
    if ({CH1_STB, CH2_STB, FRAME_ERR} !== 3'b000) begin
      fails++;
      $display("FAIL reset_pulses: got %b exp 000",
               {CH1_STB, CH2_STB, FRAME_ERR});
    end
  endtask

  task automatic test_ch1();
    int a1, a2, ae;
    a1 = n1; a2 = n2; ae = ne;
    send_bits(16'h00A5, 16);
    LOAD_SHIFT = 1'b1;
    tick(3);
    tests++;
    if (CH1_OUT !== 8'h80) begin
      fails++;
      $display("FAIL ch1_early: got %h exp 80", CH1_OUT);
    end
    tick(1);
    tests++;
    if (CH1_OUT !== 8'hA5 || CH1_STB !== 1'b1 || MIX_OUT !== 9'h100) begin
      fails++;
      $display("FAIL ch1_latency: got ch1=%h stb=%b mix=%h exp A5 1 100",
               CH1_OUT, CH1_STB, MIX_OUT);
    end
    tick(1);
    tests++;
    if (MIX_OUT !== 9'h125 || CH1_STB !== 1'b0) begin
      fails++;
      $display("FAIL ch1_mix: got mix=%h stb=%b exp 125 0",
               MIX_OUT, CH1_STB);
    end
    tick(5);
    tests++;
    if (n1 - a1 !== 1 || n2 !== a2 || ne !== ae || CH2_OUT !== 8'h80) begin
      fails++;
      $display("FAIL ch1_counts: got s1=%0d s2=%0d e=%0d ch2=%h exp 1 0 0 80",
               n1 - a1, n2 - a2, ne - ae, CH2_OUT);
    end
  endtask

  task automatic test_two_channels();
    int a1, a2;
    a1 = n1; a2 = n2;
    send_frame(16'h013C, 16);
    send_frame(16'h00FF, 16);
    tests++;
    if (CH1_OUT !== 8'hFF || CH2_OUT !== 8'h3C || MIX_OUT !== 9'h13B) begin
      fails++;
      $display("FAIL two_ch: got %h %h %h exp FF 3C 13B",
               CH1_OUT, CH2_OUT, MIX_OUT);
    end
    tests++;
    if (n1 - a1 !== 1 || n2 - a2 !== 1) begin
      fails++;
      $display("FAIL two_ch_stb: got %0d %0d exp 1 1", n1 - a1, n2 - a2);
    end
  endtask

  task automatic test_frame_err();
    int a1, a2, ae;
    a1 = n1; a2 = n2; ae = ne;
    send_frame(16'h0011, 15);
    tests++;
    if (ne - ae !== 1 || n1 !== a1 || n2 !== a2) begin
      fails++;
      $display("FAIL err15: got e=%0d s1=%0d s2=%0d exp 1 0 0",
               ne - ae, n1 - a1, n2 - a2);
    end
    send_frame(16'h0011, 17);
    tests++;
    if (ne - ae !== 2 || n1 !== a1) begin
      fails++;
      $display("FAIL err17: got e=%0d s1=%0d exp 2 0", ne - ae, n1 - a1);
    end
    send_frame(16'h0000, 48);
    tests++;
    if (ne - ae !== 3 || n1 !== a1 || n2 !== a2) begin
      fails++;
      $display("FAIL err48: got e=%0d s1=%0d s2=%0d exp 3 0 0",
               ne - ae, n1 - a1, n2 - a2);
    end
    tests++;
    if (CH1_OUT !== 8'hFF || CH2_OUT !== 8'h3C) begin
      fails++;
      $display("FAIL err_hold: got %h %h exp FF 3C", CH1_OUT, CH2_OUT);
    end
  endtask

  task automatic test_bad_addr();
    int a1, a2, ae;
    a1 = n1; a2 = n2; ae = ne;
    send_frame(16'h0755, 16);
    tests++;
    if (n1 !== a1 || n2 !== a2 || ne !== ae) begin
      fails++;
      $display("FAIL bad_addr: got s1=%0d s2=%0d e=%0d exp 0 0 0",
               n1 - a1, n2 - a2, ne - ae);
    end
    tests++;
    if (CH1_OUT !== 8'hFF || CH2_OUT !== 8'h3C || MIX_OUT !== 9'h13B) begin
      fails++;
      $display("FAIL bad_addr_hold: got %h %h %h exp FF 3C 13B",
               CH1_OUT, CH2_OUT, MIX_OUT);
    end
  endtask

  task automatic test_reset_midframe();
    int ae;
    send_bits(16'h00A5, 9);
    RESET = 1'b1;
    #1;
    tests++;
    if (CH1_OUT !== 8'h80 || CH2_OUT !== 8'h80 || MIX_OUT !== 9'h100) begin
      fails++;
      $display("FAIL mid_reset: got %h %h %h exp 80 80 100",
               CH1_OUT, CH2_OUT, MIX_OUT);
    end
    LOAD_SHIFT = 1'b1;
    SCLK       = 1'b1;
    tick(3);
    RESET = 1'b0;
    tick(4);
    ae = ne;
    send_frame(16'h0042, 16);
    tests++;
    if (CH1_OUT !== 8'h42 || CH2_OUT !== 8'h80 || MIX_OUT !== 9'h0C2) begin
      fails++;
      $display("FAIL post_reset: got %h %h %h exp 42 80 0C2",
               CH1_OUT, CH2_OUT, MIX_OUT);
    end
    tests++;
    if (ne !== ae) begin
      fails++;
      $display("FAIL post_reset_err: got %0d exp 0", ne - ae);
    end
  endtask

  task automatic test_back_to_back();
    int         a1, a2, ae;
    logic [7:0] d;
    logic [7:0] got;
    a1 = n1; a2 = n2; ae = ne;
    for (int f = 0; f < 100; f++) begin
      d = 8'($urandom_range(0, 255));
      send_frame({7'd0, f[0], d}, 16);
      got = f[0] ? CH2_OUT : CH1_OUT;
      tests++;
      if (got !== d) begin
        fails++;
        $display("FAIL b2b_frame%0d: got %h exp %h", f, got, d);
      end
    end
    tests++;
    if (n1 - a1 !== 50 || n2 - a2 !== 50) begin
      fails++;
      $display("FAIL b2b_stb: got %0d %0d exp 50 50", n1 - a1, n2 - a2);
    end
    tests++;
    if (ne !== ae) begin
      fails++;
      $display("FAIL b2b_err: got %0d exp 0", ne - ae);
    end
  endtask

  initial begin
    RESET      = 1'b0;
    SCLK       = 1'b1;
    LOAD_SHIFT = 1'b1;
    DI         = 1'b0;
    #2;
    RESET = 1'b1;
    tick(3);
    test_reset();
    RESET = 1'b0;
    tick(3);
    test_reset();
    test_ch1();
    test_two_channels();
    test_frame_err();
    test_bad_addr();
    test_reset_midframe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
